// File: rtl/bin2bcd_disp_if.sv
// Request channel of the binary-to-BCD display converter: a value plus a valid/ready handshake.
// The master drives i_valid/i_data, and the converter (slave) answers with o_ready.
interface bin2bcd_disp_if #(
   parameter int DATA_W = 32
) ();

   logic              i_valid;
   logic [DATA_W-1:0] i_data;
   logic              o_ready;

   modport master (
      output i_valid,
      output i_data,
      input  o_ready
   );

   modport slave (
      input  i_valid,
      input  i_data,
      output o_ready
   );

endinterface : bin2bcd_disp_if

// File: rtl/bin2bcd_disp.sv
// Sequential double-dabble converter (one bit per clock) feeding an 8-digit seven-segment stage.
// Optional macro BCD_BLANK_LEADING_ZERO_EN blanks leading zero digits with code 4'hF.
module bin2bcd_disp #(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   bin2bcd_disp_if.slave     io_req,
   output logic              o_valid,
   output logic              o_ovf,
   output logic [6:0]        io_hex0_o,
   output logic [6:0]        io_hex1_o,
   output logic [6:0]        io_hex2_o,
   output logic [6:0]        io_hex3_o,
   output logic [6:0]        io_hex4_o,
   output logic [6:0]        io_hex5_o,
   output logic [6:0]        io_hex6_o,
   output logic [6:0]        io_hex7_o
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] SAT_VAL  = DATA_W'(99_999_999);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;

   logic [DATA_W-1:0] r_bin;
   logic [31:0]       r_scratch;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic              r_pend_ovf;

   logic [31:0]       w_corr;
   logic [7:0][3:0]   w_digit;
   logic              w_sat;

   logic [7:0][3:0]   r_hex;
   logic              r_valid;
   logic              r_ovf;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      // NOTE: state and data registers use non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a value unassigned and infer a latch.
      w_state_nxt    = r_state;
      io_req.o_ready = 1'b0;
      w_accept       = 1'b0;
      case (r_state)
         S_IDLE: begin
            io_req.o_ready = 1'b1;
            if (io_req.i_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Double-dabble datapath
   // ------------------------------------------------------------------
   assign w_sat = (io_req.i_data > SAT_VAL);

   // Add-3 correction of all eight nibbles, each from its own pre-correction value.
   always_comb begin
      w_corr = r_scratch;
      for (int k = 0; k < 8; k++) begin
         if (r_scratch[4*k +: 4] >= 4'd5) begin
            w_corr[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
         end
      end
   end

   // NOTE: the working registers carry no reset; they are always loaded at
   // accept before being read, and reset already forces the FSM to IDLE.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_bin      <= w_sat ? SAT_VAL : io_req.i_data;
         r_pend_ovf <= w_sat;
         r_scratch  <= '0;
         r_bit_cnt  <= '0;
      end else if (r_state == S_SHIFT) begin
         {r_scratch, r_bin} <= {w_corr, r_bin} << 1;
         r_bit_cnt          <= r_bit_cnt + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Digit formatting
   // ------------------------------------------------------------------
`ifdef BCD_BLANK_LEADING_ZERO_EN
   logic w_lead;

   // Walk down from the top digit; stay blank until the first non-zero nibble.
   always_comb begin
      w_lead     = 1'b1;
      w_digit    = r_scratch;
      for (int k = 7; k >= 1; k--) begin
         if (r_scratch[4*k +: 4] != 4'd0) begin
            w_lead = 1'b0;
         end
         if (w_lead) begin
            w_digit[k] = 4'hF;
         end
      end
   end
`else
   assign w_digit = r_scratch;
`endif

   // ------------------------------------------------------------------
   // Registered display outputs, all eight digits updated together
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hex   <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_hex <= w_digit;
            r_ovf <= r_pend_ovf;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_ovf     = r_ovf;
   assign io_hex0_o = {3'b000, r_hex[0]};
   assign io_hex1_o = {3'b000, r_hex[1]};
   assign io_hex2_o = {3'b000, r_hex[2]};
   assign io_hex3_o = {3'b000, r_hex[3]};
   assign io_hex4_o = {3'b000, r_hex[4]};
   assign io_hex5_o = {3'b000, r_hex[5]};
   assign io_hex6_o = {3'b000, r_hex[6]};
   assign io_hex7_o = {3'b000, r_hex[7]};

endmodule : bin2bcd_disp

// File: tb/tb_bin2bcd_disp.sv
// Self-checking bench for bin2bcd_disp: directed boundary cases plus random values
// compared against a divide/modulo reference model of the 8-digit display.
module tb_bin2bcd_disp;

   localparam int DATA_W = 32;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       o_valid;
   logic       o_ovf;
   logic [6:0] h0, h1, h2, h3, h4, h5, h6, h7;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [55:0] exp_disp;
   logic        exp_ovf;

   bin2bcd_disp_if #(.DATA_W(DATA_W)) req_if ();

   bin2bcd_disp #(.DATA_W(DATA_W)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .io_req    (req_if),
      .o_valid   (o_valid),
      .o_ovf     (o_ovf),
      .io_hex0_o (h0),
      .io_hex1_o (h1),
      .io_hex2_o (h2),
      .io_hex3_o (h3),
      .io_hex4_o (h4),
      .io_hex5_o (h5),
      .io_hex6_o (h6),
      .io_hex7_o (h7)
   );

   always #5 i_clk = ~i_clk;

   // Reference: saturate, then take decimal digits by division; optional blanking above the top digit.
   function automatic logic [55:0] model_disp(input longint v);
      longint      s;
      longint      p;
      longint      d;
      logic [55:0] r;
      s = (v > 64'd99_999_999) ? 64'd99_999_999 : v;
      p = 1;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         d = (s / p) % 10;
`ifdef BCD_BLANK_LEADING_ZERO_EN
         if (k > 0 && s < p) d = 15;
`endif
         r[7*k +: 7] = {3'b000, 4'(d)};
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [55:0] disp();
      return {h7, h6, h5, h4, h3, h2, h1, h0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_conv(input logic [31:0] v, input string tag);
      int          n;
      logic        held;
      logic [55:0] prev;
      logic        prev_ovf;
      n = 0;
      while (req_if.o_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check({tag, " ready_before"}, 64'(req_if.o_ready), 64'd1);
      prev     = exp_disp;
      prev_ovf = exp_ovf;
      req_if.i_valid = 1'b1;
      req_if.i_data  = v;
      tick();
      req_if.i_valid = 1'b0;
      req_if.i_data  = $urandom;
      check({tag, " busy"}, 64'(req_if.o_ready), 64'd0);
      held = 1'b1;
      n    = 0;
      while (o_valid !== 1'b1 && n < 60) begin
         if (disp() !== prev || o_ovf !== prev_ovf) held = 1'b0;
         tick();
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(DATA_W + 1));
      check({tag, " hold"}, 64'(held), 64'd1);
      exp_disp = model_disp(longint'(v));
      exp_ovf  = (v > 32'd99_999_999);
      check({tag, " digits"}, 64'(disp()), 64'(exp_disp));
      check({tag, " ovf"}, 64'(o_ovf), 64'(exp_ovf));
      check({tag, " ready_after"}, 64'(req_if.o_ready), 64'd1);
      tick();
      check({tag, " pulse"}, 64'(o_valid), 64'd0);
   endtask

   initial begin
      int          pulses;
      logic [31:0] rv;

      i_rst          = 1'b1;
      req_if.i_valid = 1'b0;
      req_if.i_data  = '0;
      exp_disp       = '0;
      exp_ovf        = 1'b0;
      repeat (2) tick();
      i_rst = 1'b0;
      check("rst digits", 64'(disp()), 64'd0);
      check("rst valid", 64'(o_valid), 64'd0);
      check("rst ovf", 64'(o_ovf), 64'd0);
      check("rst ready", 64'(req_if.o_ready), 64'd1);

      do_conv(32'd12_345_678, "normal");
      do_conv(32'd99_999_999, "max");
      do_conv(32'd100_000_000, "over");
      do_conv(32'd0, "zero");
      do_conv(32'hFFFF_FFFF, "allones");
      do_conv(32'd10_000_000, "ten_m");
      do_conv(32'd1287, "small");

      // Busy-drop: 42 held on the bus while the converter is busy must be ignored.
      req_if.i_valid = 1'b1;
      req_if.i_data  = 32'd1287;
      tick();
      req_if.i_data  = 32'd42;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_valid === 1'b1) pulses++;
      end
      req_if.i_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_valid === 1'b1) pulses++;
      end
      exp_disp = model_disp(64'd1287);
      exp_ovf  = 1'b0;
      check("drop pulses", 64'(pulses), 64'd1);
      check("drop digits", 64'(disp()), 64'(exp_disp));
      do_conv(32'd42, "after_drop");

      for (int i = 0; i < 8; i++) begin
         rv = (i < 6) ? 32'($urandom_range(0, 99_999_999)) : 32'($urandom);
         do_conv(rv, $sformatf("rand%0d", i));
      end

      // Reset mid-conversion, with o_ovf set beforehand so its clearing is visible.
      do_conv(32'hFFFF_FFFF, "pre_rst");
      req_if.i_valid = 1'b1;
      req_if.i_data  = 32'd555;
      tick();
      req_if.i_valid = 1'b0;
      repeat (9) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      exp_disp = '0;
      exp_ovf  = 1'b0;
      check("midrst digits", 64'(disp()), 64'd0);
      check("midrst ovf", 64'(o_ovf), 64'd0);
      check("midrst ready", 64'(req_if.o_ready), 64'd1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (o_valid === 1'b1) pulses++;
      end
      check("midrst no_valid", 64'(pulses), 64'd0);
      do_conv(32'd7, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bin2bcd_disp
